// File: rtl/nios_onchip_memory_arbiter_pkg.sv
// Shared types and default sizing for the two-master on-chip memory arbiter.
package nios_onchip_memory_arbiter_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_LOCK = 16;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nios_onchip_memory_arbiter_rr.sv
// Two-input round-robin grant: on a tie the master not granted last wins.
module nios_rr_arbiter2
  import nios_onchip_memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/nios_onchip_memory_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters with
// round-robin fairness and a time-bounded per-master lock.
//   state | meaning
//   FREE  | round-robin between both masters
//   OWN0  | m0 holds the lock; only m0 may be granted
//   OWN1  | m1 holds the lock; only m1 may be granted
module nios_onchip_memory_arbiter
  import nios_onchip_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdv0_q, rdv1_q;
  logic [1:0]       req;
  logic [1:0]       rr_gnt;
  logic [1:0]       gnt;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  nios_rr_arbiter2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    gnt     = 2'b00;
    case (state_q)
      FREE: begin
        gnt = rr_gnt;
        if (gnt[0] && m0_lock) begin
          state_d = OWN0;
        end else if (gnt[1] && m1_lock) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        gnt[0] = req[0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Timeout: point at the owner so the waiting master wins the next tie.
          state_d = FREE;
          last_d  = 1'b0;
        end else if (gnt[0] && !m0_lock) begin
          state_d = FREE;
        end
      end
      OWN1: begin
        gnt[1] = req[1];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FREE;
          last_d  = 1'b1;
        end else if (gnt[1] && !m1_lock) begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
    // A transfer presented while reset is asserted is never accepted.
    if (!reset_n) begin
      gnt = 2'b00;
    end
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FREE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rdv0_q  <= 1'b0;
      rdv1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdv0_q  <= gnt[0] & m0_read & ~m0_write;
      rdv1_q  <= gnt[1] & m1_read & ~m1_write;
    end
  end

  assign mem_address    = gnt[1] ? m1_address    : m0_address;
  assign mem_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt[1] ? m1_writedata  : m0_writedata;
  assign mem_write      = (gnt[0] & m0_write) | (gnt[1] & m1_write);
  assign mem_chipselect = |gnt;
  assign mem_clken      = reset_n;

  assign m0_waitrequest   = ~gnt[0];
  assign m1_waitrequest   = ~gnt[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rdv0_q & reset_n;
  assign m1_readdatavalid = rdv1_q & reset_n;

endmodule

// File: tb/tb_nios_onchip_memory_arbiter.sv
// Directed bench for the arbiter with a behavioural byte-enabled RAM behind it.
module tb_nios_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  logic [31:0] mem_arr [0:1023];
  logic [9:0]  addr_q;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  nios_onchip_memory_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // RAM: registered address, unregistered read data, byte-enabled writes.
  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'hA500_0000 | 32'(i);
    addr_q <= '0;
  end

  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      addr_q <= mem_address;
    end
  end

  assign mem_readdata = mem_arr[addr_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [9:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic lk);
    m0_read = rd; m0_write = wr; m0_address = a;
    m0_byteenable = be; m0_writedata = wd; m0_lock = lk;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [9:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic lk);
    m1_read = rd; m1_write = wr; m1_address = a;
    m1_byteenable = be; m1_writedata = wd; m1_lock = lk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 0);
    drv1(0, 0, 10'h0, 4'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_we", mem_write, 0);
    chk("rst_clken", mem_clken, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdv1", m1_readdatavalid, 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_clken", mem_clken, 1);
    chk("idle_cs", mem_chipselect, 0);
    step();

    // Contention: both read every cycle, grants alternate starting with m0.
    drv0(1, 0, 10'h100, 4'hF, 32'h0, 0);
    drv1(1, 0, 10'h200, 4'hF, 32'h0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("cont_wait0_%0d", k), m0_waitrequest, 32'(k % 2));
      chk($sformatf("cont_wait1_%0d", k), m1_waitrequest, 32'(1 - k % 2));
      if (k > 0) begin
        chk($sformatf("cont_rdv0_%0d", k), m0_readdatavalid, 32'(1 - (k - 1) % 2));
        chk($sformatf("cont_rdv1_%0d", k), m1_readdatavalid, 32'((k - 1) % 2));
        chk($sformatf("cont_data_%0d", k), m1_readdata,
            ((k - 1) % 2 == 0) ? 32'hA500_0100 : 32'hA500_0200);
      end
      step();
    end
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 0);
    drv1(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("cont_last_rdv1", m1_readdatavalid, 1);
    chk("cont_last_rdv0", m0_readdatavalid, 0);
    chk("cont_last_data", m1_readdata, 32'hA500_0200);
    step();

    // Single master write then read-back.
    drv0(0, 1, 10'h005, 4'hF, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("wr_wait0", m0_waitrequest, 0);
    chk("wr_cs", mem_chipselect, 1);
    chk("wr_we", mem_write, 1);
    chk("wr_addr", mem_address, 10'h005);
    step();
    drv0(1, 0, 10'h005, 4'hF, 32'h0, 0);
    @(negedge clk);
    chk("rd_wait0", m0_waitrequest, 0);
    chk("rd_we", mem_write, 0);
    chk("wr_no_rdv", m0_readdatavalid, 0);
    step();
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("rd_rdv0", m0_readdatavalid, 1);
    chk("rd_data", m0_readdata, 32'hDEAD_BEEF);
    chk("rd_idle_cs", mem_chipselect, 0);
    step();

    // Byte-enabled partial write.
    drv0(0, 1, 10'h3FF, 4'hF, 32'hFFFF_FFFF, 0);
    step();
    drv0(0, 1, 10'h3FF, 4'b0101, 32'h1122_3344, 0);
    step();
    drv0(1, 0, 10'h3FF, 4'hF, 32'h0, 0);
    step();
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("be_rdv0", m0_readdatavalid, 1);
    chk("be_data", m0_readdata, 32'hFF22_FF44);
    step();

    // Lock: m0 was granted last, so m1 wins the tie and takes the lock.
    drv0(1, 0, 10'h020, 4'hF, 32'h0, 0);
    drv1(1, 0, 10'h010, 4'hF, 32'h0, 1);
    @(negedge clk);
    chk("lk_wait1", m1_waitrequest, 0);
    chk("lk_wait0_a", m0_waitrequest, 1);
    step();
    drv1(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("lk_wait0_b", m0_waitrequest, 1);
    chk("lk_rdv1", m1_readdatavalid, 1);
    chk("lk_data", m1_readdata, 32'hA500_0010);
    step();
    drv1(0, 1, 10'h010, 4'hF, 32'hCAFE_F00D, 0);
    @(negedge clk);
    chk("lk_unlock_wait1", m1_waitrequest, 0);
    chk("lk_wait0_c", m0_waitrequest, 1);
    step();
    drv1(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("lk_m0_after", m0_waitrequest, 0);
    step();
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("lk_m0_rdv", m0_readdatavalid, 1);
    chk("lk_m0_data", m0_readdata, 32'hA500_0020);
    step();

    // Lock timeout: m0 locks then idles with lock held; m1 waits 16 cycles.
    drv0(1, 0, 10'h030, 4'hF, 32'h0, 1);
    @(negedge clk);
    chk("to_take", m0_waitrequest, 0);
    step();
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 1);
    drv1(1, 0, 10'h040, 4'hF, 32'h0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("to_hold_%0d", i), m1_waitrequest, 1);
      step();
    end
    drv0(1, 0, 10'h050, 4'hF, 32'h0, 0);
    @(negedge clk);
    chk("to_wait1", m1_waitrequest, 0);
    chk("to_tie_wait0", m0_waitrequest, 1);
    step();
    drv1(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("to_m0_next", m0_waitrequest, 0);
    chk("to_rdv1", m1_readdatavalid, 1);
    chk("to_data", m1_readdata, 32'hA500_0040);
    step();
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 0);
    step();

    // Reset in the cycle after an accepted read.
    drv0(1, 0, 10'h060, 4'hF, 32'h0, 0);
    @(negedge clk);
    chk("rs_acc", m0_waitrequest, 0);
    step();
    reset_n = 1'b0;
    drv1(1, 0, 10'h070, 4'hF, 32'h0, 0);
    @(negedge clk);
    chk("rs_rdv0", m0_readdatavalid, 0);
    chk("rs_wait0", m0_waitrequest, 1);
    chk("rs_wait1", m1_waitrequest, 1);
    chk("rs_cs", mem_chipselect, 0);
    chk("rs_clken", mem_clken, 0);
    step();
    @(negedge clk);
    chk("rs_wait0_b", m0_waitrequest, 1);
    chk("rs_rdv0_b", m0_readdatavalid, 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rs_tie_wait0", m0_waitrequest, 0);
    chk("rs_tie_wait1", m1_waitrequest, 1);
    step();
    drv0(0, 0, 10'h0, 4'h0, 32'h0, 0);
    drv1(0, 0, 10'h0, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("rs_post_rdv0", m0_readdatavalid, 1);
    chk("rs_post_data", m0_readdata, 32'hA500_0060);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
